// File: rtl/alu_pkg.sv
// Shared definitions for the ALU result display path: FSM encoding,
// seven-segment constants and the BCD digit pattern table.
package alu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_LOAD  = 2'd2
    } state_t;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}.
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    // Pattern for one BCD digit; non-decimal codes render blank.
    function automatic logic [6:0] seg_pattern(input logic [3:0] digit);
        logic [6:0] pat;
        case (digit)
            4'd0:    pat = 7'h40;
            4'd1:    pat = 7'h79;
            4'd2:    pat = 7'h24;
            4'd3:    pat = 7'h30;
            4'd4:    pat = 7'h19;
            4'd5:    pat = 7'h12;
            4'd6:    pat = 7'h02;
            4'd7:    pat = 7'h78;
            4'd8:    pat = 7'h00;
            4'd9:    pat = 7'h10;
            default: pat = SEG_BLANK;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD digit to active-low seven-segment pattern, with blanking.
import alu_pkg::*;

module seg7_decode (
    input  logic [3:0] bcd,
    input  logic       blank,
    output logic [6:0] seg
);

    // Blank overrides the digit pattern.
    always_comb begin
        seg = blank ? SEG_BLANK : seg_pattern(bcd);
    end

endmodule

// File: rtl/alu_result_display.sv
// Captures an ALU result, converts it to BCD with a sequential double-dabble
// engine and drives a multiplexed seven-segment display.
//
// Handshake: a result is taken on a rising edge where in_valid=1 and the
// FSM is IDLE. busy is high from that edge until the edge ending LOAD;
// in_valid is ignored meanwhile (no queueing). done pulses for one cycle
// at the same edge the new value reaches the display registers.
import alu_pkg::*;

module alu_result_display #(
    parameter int WIDTH    = 6,
    parameter int NDIG     = 4,
    parameter int SCAN_DIV = 1000,
    parameter int BLANK_LZ = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [2*WIDTH-1:0] res_in,
    input  logic               ovf_in,
    input  logic               in_valid,
    output logic               busy,
    output logic               done,
    output logic [NDIG-1:0]    an,
    output logic [6:0]         seg
);

    localparam int RW  = 2 * WIDTH;
    localparam int BW  = 4 * (NDIG + 1);
    localparam int CW  = $clog2(RW + 1);
    localparam int SCW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int IW  = (NDIG > 1) ? $clog2(NDIG) : 1;

    state_t                 state, state_next;
    logic [RW-1:0]          bin_r;
    logic [BW-1:0]          bcd_r, bcd_adj;
    logic                   ovf_r;
    logic [CW-1:0]          bit_cnt;
    logic                   err;
    logic                   zero_above;
    logic [NDIG-1:0]        blank_k;
    logic [NDIG-1:0][6:0]   dec_seg;
    logic [NDIG-1:0][6:0]   disp_seg, disp_next;
    logic [SCW-1:0]         scan_cnt;
    logic [IW-1:0]          scan_idx, scan_idx_next;
    logic                   scan_wrap;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    // Next state: capture, exactly RW shift cycles, one load cycle.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (in_valid) state_next = ST_SHIFT;
            ST_SHIFT: if (bit_cnt == CW'(RW - 1)) state_next = ST_LOAD;
            ST_LOAD:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Add-3 correction on every nibble that would overflow past 9 when doubled.
    always_comb begin
        bcd_adj = bcd_r;
        for (int k = 0; k <= NDIG; k++) begin
            if (bcd_r[4*k +: 4] >= 4'd5) bcd_adj[4*k +: 4] = bcd_r[4*k +: 4] + 4'd3;
        end
    end

    // Conversion datapath: load on capture, shift {bcd,bin} left while converting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin_r   <= '0;
            bcd_r   <= '0;
            ovf_r   <= 1'b0;
            bit_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        bin_r   <= res_in;
                        ovf_r   <= ovf_in;
                        bcd_r   <= '0;
                        bit_cnt <= '0;
                    end
                end
                ST_SHIFT: begin
                    bcd_r   <= {bcd_adj[BW-2:0], bin_r[RW-1]};
                    bin_r   <= {bin_r[RW-2:0], 1'b0};
                    bit_cnt <= bit_cnt + CW'(1);
                end
                default: ;
            endcase
        end
    end

    // Overflow flag or a non-zero extra top digit means the value cannot be shown.
    assign err = ovf_r | (bcd_r[4*NDIG +: 4] != 4'd0);

    // Leading-zero blanking: digit k>0 blanks when it and every higher digit is 0.
    always_comb begin
        zero_above = 1'b1;
        blank_k    = '0;
        for (int k = NDIG - 1; k >= 0; k--) begin
            zero_above = zero_above & (bcd_r[4*k +: 4] == 4'd0);
            blank_k[k] = (BLANK_LZ != 0) && (k != 0) && zero_above;
        end
    end

    for (genvar g = 0; g < NDIG; g++) begin : g_dec
        seg7_decode u_dec (
            .bcd   (bcd_r[4*g +: 4]),
            .blank (blank_k[g]),
            .seg   (dec_seg[g])
        );
    end

    // Display contents after this edge: new patterns in LOAD, otherwise held.
    always_comb begin
        disp_next = disp_seg;
        if (state == ST_LOAD) begin
            for (int k = 0; k < NDIG; k++) disp_next[k] = err ? SEG_DASH : dec_seg[k];
        end
    end

    // Display registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) disp_seg <= {NDIG{SEG_BLANK}};
        else     disp_seg <= disp_next;
    end

    // Status outputs: busy spans capture..LOAD, done marks the display update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= (state == ST_LOAD);
            if (state == ST_IDLE && in_valid) busy <= 1'b1;
            else if (state == ST_LOAD)        busy <= 1'b0;
        end
    end

    // Digit index advance on each scan counter wrap.
    always_comb begin
        scan_wrap     = (scan_cnt == SCW'(SCAN_DIV - 1));
        scan_idx_next = scan_idx;
        if (scan_wrap) scan_idx_next = (scan_idx == IW'(NDIG - 1)) ? '0 : scan_idx + IW'(1);
    end

    // Free-running scan; an/seg registered so they only change on clock edges.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_cnt <= '0;
            scan_idx <= '0;
            an       <= '1;
            seg      <= SEG_BLANK;
        end else begin
            scan_cnt <= scan_wrap ? '0 : scan_cnt + SCW'(1);
            scan_idx <= scan_idx_next;
            an       <= ~(NDIG'(1) << scan_idx_next);
            seg      <= disp_next[scan_idx_next];
        end
    end

endmodule

// File: tb/tb_alu_result_display.sv
// Randomised scoreboard bench for alu_result_display (WIDTH=6, NDIG=4, SCAN_DIV=4).
module tb_alu_result_display;

    localparam int WIDTH    = 6;
    localparam int NDIG     = 4;
    localparam int SCAN_DIV = 4;
    localparam int LAT      = 2 * WIDTH + 1;
    localparam int EW       = 45;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] res_in = '0;
    logic        ovf_in = 1'b0;
    logic        in_valid = 1'b0;
    logic        busy, done;
    logic [3:0]  an;
    logic [6:0]  seg;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int last_cap = -100;
    int n_done = 0;
    logic [EW-1:0] exp_q[$];
    logic [6:0] dig_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    alu_result_display #(
        .WIDTH(WIDTH), .NDIG(NDIG), .SCAN_DIV(SCAN_DIV), .BLANK_LZ(1)
    ) dut (
        .clk(clk), .rst(rst), .res_in(res_in), .ovf_in(ovf_in),
        .in_valid(in_valid), .busy(busy), .done(done), .an(an), .seg(seg)
    );

    // Clock and edge counter (edges since reset release).
    always #5 clk = ~clk;
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (cyc=%0d)", name, got, exp, cyc);
        end
    endtask

    // Expected pattern of display digit k for a shown value.
    function automatic logic [6:0] exp_seg(int v, bit o, int k);
        int p = 1;
        for (int i = 0; i < k; i++) p = p * 10;
        if (o || v >= 10000) return 7'h3F;
        if (k > 0 && v < p) return 7'h7F;
        return dig_tab[(v / p) % 10];
    endfunction

    // Driver: one cycle of inputs, called at a falling edge. The model
    // accepts when idle for at least 2*WIDTH+2 cycles since last capture.
    task automatic drive(input bit v, input int r, input bit o);
        bit exp_busy;
        exp_busy = (cyc >= last_cap) && (cyc < last_cap + LAT);
        check("busy", busy, exp_busy);
        in_valid = v;
        res_in   = 12'(r);
        ovf_in   = o;
        if (v && (cyc + 1 >= last_cap + LAT + 1)) begin
            last_cap = cyc + 1;
            exp_q.push_back({32'(cyc + 1 + LAT), o, 12'(r)});
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 0, 1'b0);
    endtask

    // Asynchronous reset between clock edges; outputs must clear at once.
    task automatic do_reset(input int hold);
        #2 rst = 1'b1;
        in_valid = 1'b0;
        #1;
        check("rst_an", an, 4'hF);
        check("rst_seg", seg, 7'h7F);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        exp_q.delete();
        last_cap = -100;
        @(negedge clk);
        for (int i = 0; i < hold; i++) @(negedge clk);
        rst = 1'b0;
    endtask

    // Scan checker: digit index advances every SCAN_DIV edges after reset.
    always @(negedge clk) begin
        if (!rst && cyc >= 1)
            check("an_scan", an, 4'(~(4'b0001 << ((cyc / SCAN_DIV) % NDIG))));
    end

    // Monitor: on each done pulse pop the expected value and verify timing
    // and the pattern shown on every digit during the following scan sweep.
    initial begin
        logic [EW-1:0] e;
        logic [6:0]    got [NDIG];
        logic [NDIG-1:0] seen;
        forever begin
            @(negedge clk);
            if (!rst && exp_q.size() > 0 && int'(exp_q[0][44:13]) < cyc) begin
                check("done_missing", cyc, exp_q[0][44:13]);
                void'(exp_q.pop_front());
            end
            if (!rst && done) begin
                n_done++;
                if (exp_q.size() == 0) begin
                    check("done_unexpected", done, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    check("done_cycle", cyc, e[44:13]);
                    seen = '0;
                    for (int i = 0; i < 13; i++) begin
                        if (i > 0) @(negedge clk);
                        if (rst) break;
                        for (int k = 0; k < NDIG; k++) begin
                            if (an == 4'(~(4'b0001 << k))) begin
                                got[k]  = seg;
                                seen[k] = 1'b1;
                            end
                        end
                    end
                    if (!rst) begin
                        for (int k = 0; k < NDIG; k++) begin
                            check($sformatf("digit%0d_seen", k), seen[k], 1'b1);
                            check($sformatf("digit%0d_val%0d", k, e[11:0]), got[k],
                                  exp_seg(int'(e[11:0]), e[12], k));
                        end
                    end
                end
            end
        end
    end

    // Main stimulus sequence.
    initial begin
        int v, d0;
        repeat (3) @(negedge clk);
        check("init_an", an, 4'hF);
        check("init_seg", seg, 7'h7F);
        check("init_busy", busy, 1'b0);
        check("init_done", done, 1'b0);
        rst = 1'b0;

        // Directed values: max, small, zero, overflow flag.
        drive(1'b1, 4095, 1'b0); idle(16);
        drive(1'b1, 7, 1'b0);    idle(16);
        drive(1'b1, 0, 1'b0);    idle(16);
        drive(1'b1, 25, 1'b1);   idle(16);

        // in_valid held high with changing data: two captures in this window.
        d0 = n_done;
        for (int i = 0; i < 26; i++) drive(1'b1, $urandom_range(0, 4095), 1'b0);
        idle(16);
        check("held_valid_dones", n_done - d0, 2);

        // Random traffic including pulses while busy and during LOAD.
        for (int i = 0; i < 500; i++) begin
            case ($urandom_range(0, 7))
                0:       v = 0;
                1:       v = 4095;
                2:       v = $urandom_range(0, 9) * (10 ** $urandom_range(0, 3));
                default: v = $urandom_range(0, 4095);
            endcase
            drive($urandom_range(0, 2) == 0, v, $urandom_range(0, 7) == 0);
        end
        idle(16);

        // Reset during SHIFT: no done, blank display, then a clean reconversion.
        drive(1'b1, 123, 1'b0);
        idle(5);
        do_reset(2);
        for (int i = 0; i < 8; i++) begin
            check("blank_after_rst", seg, 7'h7F);
            drive(1'b0, 0, 1'b0);
        end
        drive(1'b1, 123, 1'b0);
        idle(20);

        check("queue_empty_end", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
